// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_pkg
//  Description : Shared types and helpers for the ring-pattern monitor.
//                Holds the FSM state encoding, direction constants and the
//                one-hot/zero word helpers. Helpers operate on a zero-extended
//                MAX_W-bit word plus a run-time width argument so a single
//                package serves every WIDTH instance.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ring_pkg;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_UP   = 2'd2,
        S_DN   = 2'd3
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Legal = all-zero or exactly one bit set within the ring width.
    // Any set bit above the ring width also makes the word illegal.
    function automatic logic onehot_legal(input word_t w, input int width);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (w[i]) begin
                if (i >= width) begin
                    ones = ones + 2;
                end else begin
                    ones = ones + 1;
                end
            end
        end
        return (ones <= 1);
    endfunction

    // Position of the lowest set bit; 0 for an all-zero word.
    function automatic int onehot_to_idx(input word_t w, input int width);
        int idx;
        idx = 0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (w[i] && (i < width)) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // Up step: bit k -> bit k+1, top bit -> zero, zero -> bit 0.
    function automatic word_t succ_up(input word_t w, input int width);
        word_t r;
        if (w == '0) begin
            r = word_t'(1);
        end else if (w[width-1]) begin
            r = '0;
        end else begin
            r = w << 1;
        end
        return r;
    endfunction

    // Down step: bit k -> bit k-1, bit 0 -> zero, zero holds at zero.
    function automatic word_t succ_dn(input word_t w, input int width);
        word_t r;
        if (width < 1) begin
            r = '0;
        end else begin
            r = w >> 1;
        end
        return r;
    endfunction

endpackage : ring_pkg
`default_nettype wire

// File: rtl/ring_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : ring_monitor_if
//  Description : Bundle between a ring-pattern source and the ring monitor.
//  Ports       : en, ring_in, clr_err            (source -> monitor)
//                idx, is_zero, dir, locked, done,
//                err, err_sticky, err_cnt          (monitor -> source)
//  Modports    : master = stimulus/observer side, slave = monitor side
//  Revision    : 1.0 - initial release
// ============================================================================
interface ring_monitor_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             en;
    logic [WIDTH-1:0] ring_in;
    logic             clr_err;
    logic [IDX_W-1:0] idx;
    logic             is_zero;
    logic             dir;
    logic             locked;
    logic             done;
    logic             err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, ring_in, clr_err,
        input  idx, is_zero, dir, locked, done, err, err_sticky, err_cnt
    );

    modport slave (
        input  en, ring_in, clr_err,
        output idx, is_zero, dir, locked, done, err, err_sticky, err_cnt
    );

endinterface : ring_monitor_if
`default_nettype wire

// File: rtl/ring_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : ring_onehot_dec
//  Description : Combinational one-hot/zero decoder.
//  Ports       : word    in  WIDTH  observed ring word
//                legal   out 1      word is zero or has exactly one bit set
//                is_zero out 1      word is all-zero
//                idx     out IDX_W  index of the set bit (0 for zero word)
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_onehot_dec
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  wire logic [WIDTH-1:0] word,
    output logic                  legal,
    output logic                  is_zero,
    output logic [IDX_W-1:0]      idx
);

    word_t w_ext;

    always_comb begin
        w_ext              = '0;
        w_ext[WIDTH-1:0]   = word;
        legal              = onehot_legal(w_ext, WIDTH);
        is_zero            = (word == '0);
        idx                = IDX_W'(onehot_to_idx(w_ext, WIDTH));
    end

endmodule : ring_onehot_dec
`default_nettype wire

// File: rtl/ring_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : ring_monitor
//  Description : Receive-side checker for a ring-counter pattern stream.
//                Decodes each enabled sample, infers shift direction, locks
//                onto the sequence and reports illegal or out-of-sequence
//                words with a pulse, a sticky flag and a saturating counter.
//  Ports       : clk      in   system clock, rising edge
//                rst      in   synchronous active-high reset
//                bus      slave modport of ring_monitor_if
//                  en, ring_in, clr_err        inputs
//                  idx, is_zero, dir, locked,
//                  done, err, err_sticky,
//                  err_cnt                     registered outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ring_monitor_if.slave  bus
);

    localparam int IDX_W = $clog2(WIDTH);

    if (WIDTH < 3) begin : g_width_check
        $error("ring_monitor: WIDTH must be 3 or more");
    end

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [IDX_W-1:0] r_idx;
    logic             r_is_zero;
    logic             r_dir;
    logic             r_locked;
    logic             r_done;
    logic             r_err;
    logic             r_err_sticky;
    logic [ERR_W-1:0] r_err_cnt;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_prev_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_is_zero_nxt;
    logic             w_dir_nxt;
    logic             w_err_nxt;
    logic             w_err_sticky_nxt;
    logic [ERR_W-1:0] w_err_cnt_nxt;
    logic             w_store;

    // Decoder on the incoming sample
    logic             w_legal;
    logic             w_is_zero;
    logic [IDX_W-1:0] w_idx;

    ring_onehot_dec #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_dec (
        .word    (bus.ring_in),
        .legal   (w_legal),
        .is_zero (w_is_zero),
        .idx     (w_idx)
    );

    // Successor comparisons are done in the package's extended word space
    word_t w_sample_ext;
    word_t w_prev_ext;
    logic  w_match_up;
    logic  w_match_dn;

    always_comb begin
        w_sample_ext            = '0;
        w_sample_ext[WIDTH-1:0] = bus.ring_in;
        w_prev_ext              = '0;
        w_prev_ext[WIDTH-1:0]   = r_prev;
        w_match_up              = (w_sample_ext == succ_up(w_prev_ext, WIDTH));
        w_match_dn              = (w_sample_ext == succ_dn(w_prev_ext, WIDTH));
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_err_nxt   = 1'b0;
        w_store     = 1'b0;

        if (bus.en) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_legal) begin
                        w_store     = 1'b1;
                        w_state_nxt = S_ACQ;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
                S_ACQ: begin
                    // Successors are always legal, so a match implies legality.
                    if (w_match_up) begin
                        w_store     = 1'b1;
                        w_state_nxt = S_UP;
                        w_dir_nxt   = DIR_UP;
                    end else if (w_match_dn) begin
                        w_store     = 1'b1;
                        w_state_nxt = S_DN;
                        w_dir_nxt   = DIR_DN;
                    end else if (w_legal) begin
                        w_store     = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_UP, S_DN: begin
                    if ((r_state == S_UP) ? w_match_up : w_match_dn) begin
                        w_store     = 1'b1;
                    end else if (w_legal) begin
                        w_store     = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_ACQ;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Sample capture and error bookkeeping
    always_comb begin
        w_prev_nxt    = r_prev;
        w_idx_nxt     = r_idx;
        w_is_zero_nxt = r_is_zero;
        if (w_store) begin
            w_prev_nxt    = bus.ring_in;
            w_idx_nxt     = w_idx;
            w_is_zero_nxt = w_is_zero;
        end

        // Clear has priority over a coincident error for sticky and count
        w_err_sticky_nxt = r_err_sticky;
        w_err_cnt_nxt    = r_err_cnt;
        if (bus.clr_err) begin
            w_err_sticky_nxt = 1'b0;
            w_err_cnt_nxt    = '0;
        end else if (w_err_nxt) begin
            w_err_sticky_nxt = 1'b1;
            if (r_err_cnt != '1) begin
                w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prev       <= '0;
            r_idx        <= '0;
            r_is_zero    <= 1'b0;
            r_dir        <= DIR_UP;
            r_locked     <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= w_prev_nxt;
            r_idx        <= w_idx_nxt;
            r_is_zero    <= w_is_zero_nxt;
            r_dir        <= w_dir_nxt;
            r_locked     <= (w_state_nxt == S_UP) || (w_state_nxt == S_DN);
            r_done       <= (w_state_nxt == S_DN) && (w_prev_nxt == '0);
            r_err        <= w_err_nxt;
            r_err_sticky <= w_err_sticky_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
        end
    end

    assign bus.idx        = r_idx;
    assign bus.is_zero    = r_is_zero;
    assign bus.dir        = r_dir;
    assign bus.locked     = r_locked;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_cnt    = r_err_cnt;

endmodule : ring_monitor
`default_nettype wire

// File: tb/tb_ring_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_monitor
//  Description : Self-checking bench for ring_monitor. A main WIDTH=4/ERR_W=8
//                instance runs a table of directed vectors; a second
//                instance with ERR_W=2 exercises counter saturation and
//                mid-stream reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_monitor;

    logic clk;
    logic rst;

    int checks;
    int failures;

    ring_monitor_if #(.WIDTH(4), .ERR_W(8)) bus_a ();
    ring_monitor_if #(.WIDTH(4), .ERR_W(2)) bus_b ();

    ring_monitor #(.WIDTH(4), .ERR_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    ring_monitor #(.WIDTH(4), .ERR_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] ring;
        logic       clr;
        logic [1:0] idx;
        logic       zero;
        logic       dir;
        logic       locked;
        logic       done;
        logic       err;
        logic       sticky;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic [3:0] ring, logic clr,
                                logic [1:0] idx, logic zero, logic dir,
                                logic locked, logic done, logic err,
                                logic sticky, logic [7:0] cnt);
        vec_t v;
        v.en = en; v.ring = ring; v.clr = clr; v.idx = idx; v.zero = zero;
        v.dir = dir; v.locked = locked; v.done = done; v.err = err;
        v.sticky = sticky; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input int row, input vec_t v);
        chk("idx",        row, 32'(bus_a.idx),        32'(v.idx));
        chk("is_zero",    row, 32'(bus_a.is_zero),    32'(v.zero));
        chk("dir",        row, 32'(bus_a.dir),        32'(v.dir));
        chk("locked",     row, 32'(bus_a.locked),     32'(v.locked));
        chk("done",       row, 32'(bus_a.done),       32'(v.done));
        chk("err",        row, 32'(bus_a.err),        32'(v.err));
        chk("err_sticky", row, 32'(bus_a.err_sticky), 32'(v.sticky));
        chk("err_cnt",    row, 32'(bus_a.err_cnt),    32'(v.cnt));
    endtask

    task automatic chk_b_zero(input int row);
        chk("b_idx",        row, 32'(bus_b.idx),        32'd0);
        chk("b_is_zero",    row, 32'(bus_b.is_zero),    32'd0);
        chk("b_dir",        row, 32'(bus_b.dir),        32'd0);
        chk("b_locked",     row, 32'(bus_b.locked),     32'd0);
        chk("b_done",       row, 32'(bus_b.done),       32'd0);
        chk("b_err",        row, 32'(bus_b.err),        32'd0);
        chk("b_err_sticky", row, 32'(bus_b.err_sticky), 32'd0);
        chk("b_err_cnt",    row, 32'(bus_b.err_cnt),    32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //                 en ring     clr idx z  d  lk dn e  st cnt
        // Up sequence from reset
        vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0100, 0, 2, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1000, 0, 3, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        // Locked up at 0010, out-of-sequence 1000, then relock via 0000/0001
        vecs.push_back(mk(1, 4'b1000, 0, 3, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        // Clear while idle on en
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        // Break lock with 1000, then follow the down sequence to terminal
        vecs.push_back(mk(1, 4'b1000, 0, 3, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 4'b0100, 0, 2, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 4'b0010, 0, 1, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 1, 1, 0, 1, 1));
        // en=0 with garbage: everything holds
        vecs.push_back(mk(0, 4'b1111, 0, 0, 1, 1, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0110, 0, 0, 1, 1, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 4'b1010, 0, 0, 1, 1, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0011, 0, 0, 1, 1, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 4'b1100, 0, 0, 1, 1, 1, 1, 0, 1, 1));
        // Leaving terminal zero: legal mismatch drops lock and done
        vecs.push_back(mk(1, 4'b0001, 0, 0, 0, 1, 0, 0, 1, 1, 2));
        vecs.push_back(mk(1, 4'b0010, 0, 1, 0, 0, 1, 0, 0, 1, 2));
        // Illegal words: back to idle, idx/is_zero untouched
        vecs.push_back(mk(1, 4'b0110, 0, 1, 0, 0, 0, 0, 1, 1, 3));
        vecs.push_back(mk(1, 4'b0110, 0, 1, 0, 0, 0, 0, 1, 1, 4));
        // Clear coincident with an error: pulse fires, clear wins
        vecs.push_back(mk(1, 4'b1010, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 4'b0100, 0, 2, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0101, 0, 1, 0, 1, 1, 0, 0, 0, 0));

        rst           = 1'b1;
        bus_a.en      = 1'b0;
        bus_a.ring_in = 4'b0000;
        bus_a.clr_err = 1'b0;
        bus_b.en      = 1'b0;
        bus_b.ring_in = 4'b0000;
        bus_b.clr_err = 1'b0;
        step();
        step();
        chk_a(-1, mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk_b_zero(-1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus_a.en      = vecs[i].en;
            bus_a.ring_in = vecs[i].ring;
            bus_a.clr_err = vecs[i].clr;
            step();
            chk_a(i, vecs[i]);
        end

        // Reset while locked down, with en and clr_err inactive/active mix
        bus_a.en      = 1'b1;
        bus_a.ring_in = 4'b0001;
        bus_a.clr_err = 1'b0;
        rst           = 1'b1;
        step();
        chk_a(100, mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst      = 1'b0;
        bus_a.en = 1'b0;

        // Narrow counter: five illegal words saturate at 3
        bus_b.en      = 1'b1;
        bus_b.ring_in = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("b_err",     200 + i, 32'(bus_b.err),        32'd1);
            chk("b_sticky",  200 + i, 32'(bus_b.err_sticky), 32'd1);
            chk("b_err_cnt", 200 + i, 32'(bus_b.err_cnt),    32'((i < 3) ? i + 1 : 3));
        end

        // Mid-stream reset still returns everything to zero
        rst = 1'b1;
        step();
        chk_b_zero(300);
        rst      = 1'b0;
        bus_b.en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ring_monitor
`default_nettype wire
